imem_loader: RTL

- Byte-stream program loader and the write side of instruction memory.
- Accepts a length-prefixed byte stream, assembles big-endian 32-bit words and issues single-cycle word writes into the instruction RAM, starting at the text base.
- Holds the CPU in reset while loading, so the fetch unit restarts at the text base once the load completes.

---
 rtl/imem_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader driving the write port of the
// instruction RAM.
//
// The stream is a 16-bit big-endian word count, followed by that many
// big-endian 32-bit words. Each word is written with a one-cycle strobe to
// TEXT_BASE + 4*index. The CPU is held in reset for the whole load.
//
// Optional feature (define IMEM_LOADER_CSUM_EN): one trailing checksum byte,
// the XOR of all data bytes. On a mismatch the load ends with out_err and
// no out_done.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   in_start        one-cycle request to begin a load (honoured only in IDLE)
//   in_valid        in_byte is valid this cycle
//   in_byte         stream byte
//   out_ready       loader accepts in_byte this cycle
//   out_we          instruction RAM write strobe, one cycle per word
//   out_waddr       byte address of the current/last write
//   out_wdata       assembled word of the current/last write
//   out_cpu_hold    keeps the CPU in reset while high
//   out_done        one-cycle pulse on successful completion
//   out_err         sticky error flag, cleared by the next accepted in_start
module imem_loader #(
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        out_ready,
  output logic        out_we,
  output logic [31:0] out_waddr,
  output logic [31:0] out_wdata,
  output logic        out_cpu_hold,
  output logic        out_done,
  output logic        out_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  count_hi_q;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] shift_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        accept;
  logic [15:0] hdr_count;
  logic        word_last;
  logic        err_set;
  logic        err_clr;

  assign accept    = in_valid && out_ready;
  assign hdr_count = {count_hi_q, in_byte};
  assign word_last = ((word_idx_q + 16'd1) == count_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    out_ready    = 1'b0;
    out_cpu_hold = (state_q != S_IDLE);
    out_done     = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          state_d = S_HDR_HI;
          err_clr = 1'b1;
        end
      end
      S_HDR_HI: begin
        out_ready = 1'b1;
        if (accept) state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        out_ready = 1'b1;
        if (accept) begin
          if (hdr_count == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, hdr_count} > DEPTH_W) begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        out_ready = 1'b1;
        if (accept && (byte_cnt_q == 2'd3) && word_last) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        out_ready = 1'b1;
        if (accept) begin
          if (in_byte == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_we     <= 1'b0;
      out_waddr  <= '0;
      out_wdata  <= '0;
      out_err    <= 1'b0;
      count_hi_q <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      out_we <= 1'b0;
      if (err_set)      out_err <= 1'b1;
      else if (err_clr) out_err <= 1'b0;

      if ((state_q == S_IDLE) && in_start) begin
        word_idx_q <= '0;
        byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_q     <= '0;
`endif
      end

      if (accept) begin
        unique case (state_q)
          S_HDR_HI: count_hi_q <= in_byte;
          S_HDR_LO: count_q    <= hdr_count;
          S_DATA: begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            shift_q    <= {shift_q[15:0], in_byte};
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= csum_q ^ in_byte;
`endif
            // The 4th byte completes the word straight from the input, so the
            // write issues the very next cycle without an extra stall.
            if (byte_cnt_q == 2'd3) begin
              out_we     <= 1'b1;
              out_wdata  <= {shift_q, in_byte};
              out_waddr  <= TEXT_BASE + 32'({word_idx_q, 2'b00});
              word_idx_q <= word_idx_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
